wb_adder_csr: RTL and testbench
===============================

// Module: wb_adder_csr
// PURPOSE
//  Wishbone-slave multi-cycle 32-bit modular adder (mod 2^32, SHA-256 word add) in the user project area.
//  Firmware loads operands, starts an add, polls status/IRQ and reads the result over the Caravel
//  management Wishbone bus. It also drives the 16-bit check field on io_out[31:16], which the
//  chip-level bench monitors for pass/fail codes (0xAB60 = started, 0xAB61 = passed).
// PARAMETERS
//  BASE_ADDR  32'h3000_0000  slave base; decode when wbs_adr_i[31:8]==BASE_ADDR[31:8]
//  CHUNK      8              adder bits resolved per cycle; legal 4/8/16/32; latency NCYC=32/CHUNK
// PORTS
//  wb_clk_i     in   1   single clock domain
//  wb_rst_n     in   1   reset, asynchronous assert, active-low
//  wbs_cyc_i    in   1   bus cycle
//  wbs_stb_i    in   1   strobe
//  wbs_we_i     in   1   1=write
//  wbs_sel_i    in   4   byte-lane enables
//  wbs_adr_i    in   32  byte address
//  wbs_dat_i    in   32  write data
//  wbs_ack_o    out  1   ack
//  wbs_dat_o    out  32  read data
//  io_out       out  16  check field, mapped to mprj io[31:16]
//  io_oeb       out  16  output enables, active-low
//  irq_o        out  1   done pulse
// BEHAVIOUR
//  Reset: all regs 0, wbs_ack_o=0, wbs_dat_o=0, io_out=0, io_oeb=16'hFFFF, irq_o=0, FSM=IDLE.
//  Map (offset[7:0]): 00 OPA rw | 04 OPB rw | 08 CTRL | 0C STATUS ro | 10 RESULT ro | 14 GPIO rw [15:0]
//  CTRL: [0] START (write-1 pulse, reads 0), [1] ACC, [2] IE, [3] GPIO_OE (1 => io_oeb=0).
//  STATUS: [0] BUSY, [1] DONE, [2] CARRY (final carry-out of the last add).
//  Bus: ack rises exactly 1 cycle after cyc&stb&decode&!ack; held 1 cycle; next req needs new cycle.
//   Writes honour wbs_sel_i per byte. Reads of unmapped offsets return 0 with ack. No decode => no ack.
//   wbs_dat_o valid only while ack=1, else 0.
//  FSM IDLE->RUN on START write when !BUSY; snapshots OPA/OPB into the core; clears DONE, sets BUSY.
//   RUN: one CHUNK per cycle, LSB chunk first, carry chained in a flop; counter 0..NCYC-1.
//   Last chunk -> DONE state for 1 cycle: RESULT, CARRY written; DONE=1, BUSY=0; if ACC, OPA<=RESULT;
//   irq_o=IE for exactly that cycle. Then IDLE. START-ack to DONE=1 visible: NCYC+1 cycles.
//  Boundaries: START while BUSY ignored (no restart, no error). OPA/OPB writes while BUSY ignored.
//   Overflow wraps mod 2^32; carry reported only. START with ACC and OPA write in same cycle impossible
//   (one access/cycle). DONE stays set until next accepted START. Reset mid-RUN aborts: all state to reset.
//  GPIO write updates io_out the cycle after ack; independent of adder FSM.
// STRUCTURE
//  Package wb_adder_pkg: register offsets (OFF_OPA..OFF_GPIO), CTRL/STATUS bit indices,
//   FSM enum {IDLE,RUN,DONE}.
//  Sub-module adder_chunk_core: operand snapshot, chunk counter, carry flop, result shift reg,
//   start/done handshake. Top holds Wishbone decode, CSRs, GPIO, IRQ.
// TESTING
//  OPA=0x12345678, OPB=0x9ABCDEF0, START -> after NCYC+1 cycles RESULT=0xACF13568, CARRY=0, DONE=1.
//  OPA=0xFFFFFFFF, OPB=1 -> RESULT=0x00000000, CARRY=1; IE=1 -> irq_o high exactly 1 cycle.
//  ACC=1, OPA=0, OPB=0x10, START x3 (wait DONE each) -> RESULT 0x10, 0x20, 0x30; OPA=0x30.
//  GPIO_OE=1, GPIO=0xAB60 then 0xAB61 -> io_out follows, io_oeb=0; sel=4'b0001 wr 0xFFFFFFFF to OPA=0
//   -> OPA=0x000000FF.
//  START, second START + OPB write mid-RUN -> ignored; result uses first operands; ack still given.
//  Assert wb_rst_n low mid-RUN -> BUSY=0, DONE=0, RESULT=0, io_oeb=FFFF immediately; no irq.

Source files
------------

// File: rtl/wb_adder_csr_pkg.sv
// Shared register map, control/status bit positions and FSM states for the
// Wishbone chunked-adder CSR block.
package wb_adder_pkg;

  localparam logic [7:0] OFF_OPA    = 8'h00;
  localparam logic [7:0] OFF_OPB    = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RESULT = 8'h10;
  localparam logic [7:0] OFF_GPIO   = 8'h14;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_ACC   = 1;
  localparam int unsigned CTRL_IE    = 2;
  localparam int unsigned CTRL_OE    = 3;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_DONE  = 1;
  localparam int unsigned STAT_CARRY = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  function automatic logic [31:0] merge_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/wb_adder_csr_adder_chunk_core.sv
// Multi-cycle 32-bit adder: snapshots operands on start, resolves CHUNK bits
// per cycle LSB-first with a registered carry, then pulses done for one cycle.
module adder_chunk_core
  import wb_adder_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry
);

  localparam int unsigned NCYC = 32 / CHUNK;
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  fsm_t            state, state_nx;
  logic [31:0]     a_q, b_q, res_q;
  logic [CW-1:0]   cnt_q;
  logic            cy_q;
  logic [CHUNK:0]  sum;
  logic [31+CHUNK:0] res_cat;
  logic            last;

  always_comb begin
    sum     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_q};
    // new chunk enters at the top; after NCYC shifts the LSB chunk lands at bit 0
    res_cat = {sum[CHUNK-1:0], res_q} >> CHUNK;
    last    = (cnt_q == CW'(NCYC - 1));
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
      cy_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a_q   <= opa;
        b_q   <= opb;
        cnt_q <= '0;
        cy_q  <= 1'b0;
      end else if (state == RUN) begin
        a_q   <= a_q >> CHUNK;
        b_q   <= b_q >> CHUNK;
        res_q <= res_cat[31:0];
        cy_q  <= sum[CHUNK];
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign result = res_q;
  assign carry  = cy_q;

endmodule

// File: rtl/wb_adder_csr.sv
// Wishbone slave wrapping the chunked adder: operand/control CSRs, status,
// result capture, done IRQ and the 16-bit GPIO check field.
module wb_adder_csr
  import wb_adder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned CHUNK     = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb,
  output logic        irq_o
);

  logic [31:0] opa_q, opb_q, result_q;
  logic [15:0] gpio_q, io_out_q;
  logic        acc_q, ie_q, oe_q, carry_q, done_q, irq_q;
  logic        hit, req, wr, core_start, core_busy, core_done, core_carry;
  logic [7:0]  off;
  logic [31:0] rd_data, opa_m, opb_m, gpio_m, core_result;

  assign hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off = wbs_adr_i[7:0];
  assign req = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
  assign wr  = req & wbs_we_i;
  assign core_start = wr && off == OFF_CTRL && wbs_sel_i[0] &&
                      wbs_dat_i[CTRL_START] && !core_busy;

  always_comb begin
    opa_m  = merge_sel(opa_q, wbs_dat_i, wbs_sel_i);
    opb_m  = merge_sel(opb_q, wbs_dat_i, wbs_sel_i);
    gpio_m = merge_sel({16'h0000, gpio_q}, wbs_dat_i, wbs_sel_i);
    rd_data = '0;
    case (off)
      OFF_OPA:    rd_data = opa_q;
      OFF_OPB:    rd_data = opb_q;
      OFF_CTRL:   rd_data = {28'h0, oe_q, ie_q, acc_q, 1'b0};
      OFF_STATUS: rd_data = {29'h0, carry_q, done_q, core_busy};
      OFF_RESULT: rd_data = result_q;
      OFF_GPIO:   rd_data = {16'h0000, gpio_q};
      default:    rd_data = '0;
    endcase
  end

  adder_chunk_core #(.CHUNK(CHUNK)) u_core (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n),
    .start  (core_start),
    .opa    (opa_q),
    .opb    (opb_q),
    .busy   (core_busy),
    .done   (core_done),
    .result (core_result),
    .carry  (core_carry)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      gpio_q    <= '0;
      io_out_q  <= '0;
      acc_q     <= 1'b0;
      ie_q      <= 1'b0;
      oe_q      <= 1'b0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rd_data : '0;
      io_out_q  <= gpio_q;
      irq_q     <= core_done & ie_q;

      if (wr && !core_busy && off == OFF_OPA) opa_q <= opa_m;
      if (wr && !core_busy && off == OFF_OPB) opb_q <= opb_m;
      if (wr && off == OFF_GPIO) gpio_q <= gpio_m[15:0];
      if (wr && off == OFF_CTRL && wbs_sel_i[0]) begin
        acc_q <= wbs_dat_i[CTRL_ACC];
        ie_q  <= wbs_dat_i[CTRL_IE];
        oe_q  <= wbs_dat_i[CTRL_OE];
      end

      // core_done implies busy, so the accumulate write never races a bus write
      if (core_done) begin
        result_q <= core_result;
        carry_q  <= core_carry;
        done_q   <= 1'b1;
        if (acc_q) opa_q <= core_result;
      end else if (core_start) begin
        done_q <= 1'b0;
      end
    end
  end

  assign io_out = io_out_q;
  assign io_oeb = oe_q ? '0 : '1;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_wb_adder_csr.sv
// Scoreboard bench for wb_adder_csr: bus accesses queue expected read data,
// a negedge monitor pops and compares on every ack.
module tb_wb_adder_csr;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int unsigned NCYC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [15:0] io_out, io_oeb;
  logic        irq;

  typedef struct {
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_adder_csr #(.BASE_ADDR(BASE), .CHUNK(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq_o     (irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got ack with dat 0x%08h expected no ack", dat_o);
      end else begin
        mon_e = sb.pop_front();
        chk(mon_e.nm, dat_o, mon_e.exp);
      end
    end
  end

  task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] exp, input string nm);
    bit got;
    exp_t e;
    e.exp = w ? 32'h0 : exp;
    e.nm  = nm;
    sb.push_back(e);
    adr = BASE | {24'h0, off};
    wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no ack expected ack", nm);
      void'(sb.pop_back());
    end
  endtask

  task automatic wr32(input logic [7:0] off, input logic [31:0] d, input string nm);
    bus(1'b1, off, d, 4'hF, 32'h0, nm);
  endtask

  task automatic rd32(input logic [7:0] off, input logic [31:0] exp, input string nm);
    bus(1'b0, off, 32'h0, 4'hF, exp, nm);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit got;
    bit irq_seen;
    wait_cyc(2);
    chk("reset_io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
    chk("reset_io_out", {16'h0, io_out}, 32'h0);
    chk("reset_ack_irq", {30'h0, ack, irq}, 32'h0);
    chk("reset_dat_o", dat_o, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    wait_cyc(1);
    rd32(8'h0C, 32'h0, "reset_status");
    rd32(8'h08, 32'h0, "reset_ctrl");

    // basic add with exact DONE latency
    wr32(8'h00, 32'h1234_5678, "wr_opa1");
    wr32(8'h04, 32'h9ABC_DEF0, "wr_opb1");
    wr32(8'h08, 32'h1, "start1");
    rd32(8'h0C, 32'h1, "status_busy1");
    wait_cyc(NCYC + 2);
    rd32(8'h10, 32'hACF1_3568, "result1");
    rd32(8'h0C, 32'h2, "status_done1");

    // overflow wrap, carry, single-cycle irq
    wr32(8'h00, 32'hFFFF_FFFF, "wr_opa2");
    wr32(8'h04, 32'h1, "wr_opb2");
    wr32(8'h08, 32'h5, "start2_ie");
    repeat (NCYC) @(posedge clk);
    #1 chk("irq_before", {31'h0, irq}, 32'h0);
    @(posedge clk); #1 chk("irq_pulse", {31'h0, irq}, 32'h1);
    @(posedge clk); #1 chk("irq_after", {31'h0, irq}, 32'h0);
    rd32(8'h10, 32'h0, "result2_wrap");
    rd32(8'h0C, 32'h6, "status_carry2");

    // accumulate mode
    wr32(8'h08, 32'h2, "ctrl_acc");
    wr32(8'h00, 32'h0, "wr_opa3");
    wr32(8'h04, 32'h10, "wr_opb3");
    wr32(8'h08, 32'h3, "acc_start_a");
    wait_cyc(NCYC + 2);
    rd32(8'h10, 32'h10, "acc_result_a");
    wr32(8'h08, 32'h3, "acc_start_b");
    wait_cyc(NCYC + 2);
    rd32(8'h10, 32'h20, "acc_result_b");
    wr32(8'h08, 32'h3, "acc_start_c");
    wait_cyc(NCYC + 2);
    rd32(8'h10, 32'h30, "acc_result_c");
    rd32(8'h00, 32'h30, "acc_opa");

    // GPIO and byte-lane writes
    wr32(8'h08, 32'h8, "ctrl_oe");
    wr32(8'h14, 32'h0000_AB60, "gpio_started");
    wait_cyc(2);
    chk("io_out_ab60", {16'h0, io_out}, 32'h0000_AB60);
    chk("io_oeb_on", {16'h0, io_oeb}, 32'h0);
    wr32(8'h14, 32'h0000_AB61, "gpio_passed");
    wait_cyc(2);
    chk("io_out_ab61", {16'h0, io_out}, 32'h0000_AB61);
    rd32(8'h14, 32'h0000_AB61, "gpio_read");
    wr32(8'h00, 32'h0, "opa_clear");
    bus(1'b1, 8'h00, 32'hFFFF_FFFF, 4'b0001, 32'h0, "opa_sel0");
    rd32(8'h00, 32'h0000_00FF, "opa_sel_read");
    rd32(8'h18, 32'h0, "unmapped_read");

    // no decode: no ack within a bounded window
    adr = 32'h3000_0100; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("no_decode_ack", {31'h0, got}, 32'h0);

    // START and OPB write while busy are ignored
    wr32(8'h00, 32'h1111_1111, "wr_opa4");
    wr32(8'h04, 32'h2222_2222, "wr_opb4");
    wr32(8'h08, 32'h1, "start4");
    wr32(8'h08, 32'h1, "start4_busy");
    wr32(8'h04, 32'h0000_000F, "opb4_busy");
    wait_cyc(NCYC + 2);
    rd32(8'h10, 32'h3333_3333, "result4_first_ops");
    rd32(8'h04, 32'h2222_2222, "opb4_kept");
    rd32(8'h0C, 32'h2, "status4_idle");

    // reset mid-run aborts everything
    wr32(8'h08, 32'hD, "start5_oe_ie");
    wait_cyc(2);
    rst_n = 1'b0;
    #1;
    chk("rst_io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
    chk("rst_irq_ack", {30'h0, ack, irq}, 32'h0);
    wait_cyc(2);
    @(negedge clk); rst_n = 1'b1;
    irq_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (irq) irq_seen = 1'b1;
    end
    chk("rst_no_irq", {31'h0, irq_seen}, 32'h0);
    rd32(8'h0C, 32'h0, "rst_status");
    rd32(8'h10, 32'h0, "rst_result");

    wait_cyc(2);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
